// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - job sequencer for a 2x2 output-stationary systolic multiplier
// Clears the array, streams skewed row/column operands into its edges, then captures C = A x B.
module systolic_ctrl #(
    parameter int DW = 8,
    parameter int CW = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] a11,
    input  logic [DW-1:0] a12,
    input  logic [DW-1:0] a21,
    input  logic [DW-1:0] a22,
    input  logic [DW-1:0] b11,
    input  logic [DW-1:0] b12,
    input  logic [DW-1:0] b21,
    input  logic [DW-1:0] b22,
    input  logic [CW-1:0] pc11,
    input  logic [CW-1:0] pc12,
    input  logic [CW-1:0] pc21,
    input  logic [CW-1:0] pc22,
    output logic          arr_rst_n,
    output logic [DW-1:0] arr_a1,
    output logic [DW-1:0] arr_a2,
    output logic [DW-1:0] arr_b1,
    output logic [DW-1:0] arr_b2,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] res_c11,
    output logic [CW-1:0] res_c12,
    output logic [CW-1:0] res_c21,
    output logic [CW-1:0] res_c22
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GAP,
        FEED0,
        FEED1,
        FEED2,
        DRAIN,
        CAPTURE
    } state_t;

    state_t state;

    logic [DW-1:0] op_a11;
    logic [DW-1:0] op_a12;
    logic [DW-1:0] op_a21;
    logic [DW-1:0] op_a22;
    logic [DW-1:0] op_b11;
    logic [DW-1:0] op_b12;
    logic [DW-1:0] op_b21;
    logic [DW-1:0] op_b22;

    // Feed registers are loaded on entry to each FEED state, so the array
    // samples a state's values at the edge that closes that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            arr_rst_n <= 1'b0;
            arr_a1    <= '0;
            arr_a2    <= '0;
            arr_b1    <= '0;
            arr_b2    <= '0;
            res_c11   <= '0;
            res_c12   <= '0;
            res_c21   <= '0;
            res_c22   <= '0;
            op_a11    <= '0;
            op_a12    <= '0;
            op_a21    <= '0;
            op_a22    <= '0;
            op_b11    <= '0;
            op_b12    <= '0;
            op_b21    <= '0;
            op_b22    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    arr_rst_n <= 1'b1;
                    arr_a1    <= '0;
                    arr_a2    <= '0;
                    arr_b1    <= '0;
                    arr_b2    <= '0;
                    busy      <= 1'b0;
                    if (start) begin
                        op_a11    <= a11;
                        op_a12    <= a12;
                        op_a21    <= a21;
                        op_a22    <= a22;
                        op_b11    <= b11;
                        op_b12    <= b12;
                        op_b21    <= b21;
                        op_b22    <= b22;
                        busy      <= 1'b1;
                        arr_rst_n <= 1'b0;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    arr_rst_n <= 1'b1;
                    state     <= GAP;
                end
                GAP: begin
                    arr_a1 <= op_a11;
                    arr_b1 <= op_b11;
                    arr_a2 <= '0;
                    arr_b2 <= '0;
                    state  <= FEED0;
                end
                FEED0: begin
                    arr_a1 <= op_a12;
                    arr_b1 <= op_b21;
                    arr_a2 <= op_a21;
                    arr_b2 <= op_b12;
                    state  <= FEED1;
                end
                FEED1: begin
                    arr_a1 <= '0;
                    arr_b1 <= '0;
                    arr_a2 <= op_a22;
                    arr_b2 <= op_b22;
                    state  <= FEED2;
                end
                FEED2: begin
                    arr_a1 <= '0;
                    arr_b1 <= '0;
                    arr_a2 <= '0;
                    arr_b2 <= '0;
                    state  <= DRAIN;
                end
                DRAIN: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    res_c11 <= pc11;
                    res_c12 <= pc12;
                    res_c21 <= pc21;
                    res_c22 <= pc22;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - self-checking bench for systolic_ctrl with a behavioural 2x2 array
module tb_systolic_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a11 = '0, a12 = '0, a21 = '0, a22 = '0;
    logic [7:0]  b11 = '0, b12 = '0, b21 = '0, b22 = '0;
    logic [14:0] pc11, pc12, pc21, pc22;
    logic        arr_rst_n;
    logic [7:0]  arr_a1, arr_a2, arr_b1, arr_b2;
    logic        busy, done;
    logic [14:0] res_c11, res_c12, res_c21, res_c22;

    int tests = 0;
    int failed = 0;

    logic [7:0] na[4];
    logic [7:0] nb[4];
    logic [7:0] ea[4];
    logic [7:0] eb[4];

    systolic_ctrl #(.DW(8), .CW(15)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a11(a11), .a12(a12), .a21(a21), .a22(a22),
        .b11(b11), .b12(b12), .b21(b21), .b22(b22),
        .pc11(pc11), .pc12(pc12), .pc21(pc21), .pc22(pc22),
        .arr_rst_n(arr_rst_n),
        .arr_a1(arr_a1), .arr_a2(arr_a2), .arr_b1(arr_b1), .arr_b2(arr_b2),
        .busy(busy), .done(done),
        .res_c11(res_c11), .res_c12(res_c12), .res_c21(res_c21), .res_c22(res_c22)
    );

    always #5 clk = ~clk;

    // Output-stationary array: a flows right, b flows down, each PE accumulates a*b.
    logic [14:0] acc[4];
    logic [7:0]  a_pass0, a_pass1, b_pass0, b_pass1;
    always @(posedge clk) begin
        if (!arr_rst_n) begin
            for (int i = 0; i < 4; i++) acc[i] <= '0;
            a_pass0 <= '0;
            a_pass1 <= '0;
            b_pass0 <= '0;
            b_pass1 <= '0;
        end else begin
            acc[0]  <= acc[0] + ({7'd0, arr_a1} * {7'd0, arr_b1});
            acc[1]  <= acc[1] + ({7'd0, a_pass0} * {7'd0, arr_b2});
            acc[2]  <= acc[2] + ({7'd0, arr_a2} * {7'd0, b_pass0});
            acc[3]  <= acc[3] + ({7'd0, a_pass1} * {7'd0, b_pass1});
            a_pass0 <= arr_a1;
            b_pass0 <= arr_b1;
            a_pass1 <= arr_a2;
            b_pass1 <= arr_b2;
        end
    end
    assign pc11 = acc[0];
    assign pc12 = acc[1];
    assign pc21 = acc[2];
    assign pc22 = acc[3];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] cref(input int i, input int j);
        int s;
        s = int'(ea[i*2]) * int'(eb[j]) + int'(ea[i*2+1]) * int'(eb[2+j]);
        return 15'(s % 32768);
    endfunction

    function automatic logic [31:0] feed_exp(input int k);
        case (k)
            3:       return {ea[0], eb[0], 8'd0, 8'd0};
            4:       return {ea[1], eb[2], ea[2], eb[1]};
            5:       return {8'd0, 8'd0, ea[3], eb[3]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive_ops(input logic [7:0] a[4], input logic [7:0] b[4]);
        {a11, a12, a21, a22} = {a[0], a[1], a[2], a[3]};
        {b11, b12, b21, b22} = {b[0], b[1], b[2], b[3]};
    endtask

    task automatic set_ops(input int a0, a1, a2, a3, b0, b1, b2, b3);
        na[0] = 8'(a0); na[1] = 8'(a1); na[2] = 8'(a2); na[3] = 8'(a3);
        nb[0] = 8'(b0); nb[1] = 8'(b1); nb[2] = 8'(b2); nb[3] = 8'(b3);
    endtask

    task automatic run_job(input bit keep_start, input bit disturb);
        logic [7:0] ra[4];
        logic [7:0] rb[4];
        int dones;
        ea = na;
        eb = nb;
        drive_ops(na, nb);
        start = 1'b1;
        step();
        start = keep_start;
        for (int k = 1; k <= 7; k++) begin
            check($sformatf("busy_c%0d", k), busy, 1);
            check($sformatf("done_low_c%0d", k), done, 0);
            check($sformatf("rst_n_c%0d", k), arr_rst_n, (k != 1));
            check($sformatf("feed_c%0d", k), {arr_a1, arr_b1, arr_a2, arr_b2}, feed_exp(k));
            if (disturb && k == 4) begin
                for (int i = 0; i < 4; i++) begin
                    ra[i] = 8'($urandom);
                    rb[i] = 8'($urandom);
                end
                drive_ops(ra, rb);
                start = 1'b1;
            end
            if (disturb && k == 5) start = 1'b0;
            step();
        end
        check("done_pulse", done, 1);
        check("busy_end", busy, 0);
        check("res_c11", res_c11, cref(0, 0));
        check("res_c12", res_c12, cref(0, 1));
        check("res_c21", res_c21, cref(1, 0));
        check("res_c22", res_c22, cref(1, 1));
        if (!keep_start) begin
            dones = 0;
            for (int k = 0; k < 10; k++) begin
                step();
                if (done) dones++;
                if (busy) dones += 100;
            end
            check("no_extra_job", dones, 0);
            check("res_hold", {res_c11, res_c12, res_c21, res_c22},
                  {cref(0, 0), cref(0, 1), cref(1, 0), cref(1, 1)});
        end
    endtask

    initial begin
        int dones;

        // Reset state and release.
        step();
        step();
        check("rst_arr_rst_n", arr_rst_n, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", {res_c11, res_c12, res_c21, res_c22}, 0);
        check("rst_feeds", {arr_a1, arr_b1, arr_a2, arr_b2}, 0);
        rst = 1'b0;
        step();
        check("rel_arr_rst_n", arr_rst_n, 1);
        check("rel_feeds", {arr_a1, arr_b1, arr_a2, arr_b2}, 0);
        step();
        check("rel_idle_busy", busy, 0);

        // rst wins over start in the same cycle.
        rst = 1'b1;
        start = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        step();
        check("rst_start_busy", busy, 0);
        check("rst_start_rst_n", arr_rst_n, 1);

        // Basic job.
        set_ops(1, 2, 3, 4, 5, 6, 7, 8);
        run_job(0, 0);
        check("basic_c11_const", res_c11, 19);
        check("basic_c22_const", res_c22, 50);

        // Wraparound.
        set_ops(255, 255, 255, 255, 255, 255, 255, 255);
        run_job(0, 0);
        check("wrap_const", res_c12, 31746);

        // Back-to-back jobs with start held.
        set_ops(1, 0, 0, 1, $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
        run_job(1, 0);
        set_ops($urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255), 1, 0, 0, 1);
        run_job(1, 0);
        set_ops(0, 0, 0, 0, 0, 0, 0, 0);
        run_job(0, 0);

        // Operand changes and start pulse while busy.
        set_ops(1, 2, 3, 4, 5, 6, 7, 8);
        run_job(0, 1);

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            set_ops($urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255),
                    $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
            run_job(j[0], 0);
        end
        start = 1'b0;
        step();

        // Abort in FEED1, then a clean job.
        set_ops(9, 9, 9, 9, 9, 9, 9, 9);
        drive_ops(na, nb);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("abort_in_feed1", {arr_a1, arr_b1, arr_a2, arr_b2}, {8'd9, 8'd9, 8'd9, 8'd9});
        rst = 1'b1;
        step();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rst_n", arr_rst_n, 0);
        check("abort_res", {res_c11, res_c12, res_c21, res_c22}, 0);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (done || busy) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_rst_n_rel", arr_rst_n, 1);
        set_ops(1, 2, 3, 4, 5, 6, 7, 8);
        run_job(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer that drives the 2x2 output-stationary systolic multiplier.
- Accepts one pair of 2x2 operand matrices per job, on a start pulse.
- Clears the array accumulators, then feeds skewed row and column streams into the array's edge inputs.
- After the pipeline drains, captures the four accumulator outputs into result registers and pulses done.
- Sits between the host/register interface and the array instance.

Parameters:
DW, 8, operand element width (unsigned)
CW, 15, accumulator/result width; results are the array's C values modulo 2^CW

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  job request; sampled only in IDLE
a11, a12, a21, a22  input  DW each  matrix A elements, row-column order
b11, b12, b21, b22  input  DW each  matrix B elements
pc11, pc12, pc21, pc22  input  CW each  accumulator outputs from array PEs (0,0), (0,1), (1,0), (1,1)
arr_rst_n  output  1  registered active-low clear to the array
arr_a1, arr_a2  output  DW each  registered row-0 / row-1 left-edge feeds
arr_b1, arr_b2  output  DW each  registered col-0 / col-1 top-edge feeds
busy  output  1  job in progress
done  output  1  one-cycle pulse; res_* valid from this cycle
res_c11, res_c12, res_c21, res_c22  output  CW each  registered results C = A x B

Behaviour:
- Clock and reset: one clock domain; rst synchronous active-high; all registers update on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, arr_rst_n=0, arr_a*/arr_b*=0, res_*=0, operand latches=0.
- While rst=1, arr_rst_n stays 0, which also clears the array.
- First edge with rst=0: arr_rst_n<=1.
- States: IDLE, CLEAR, GAP, FEED0, FEED1, FEED2, DRAIN, CAPTURE.
- IDLE:
  - arr_rst_n=1, feeds=0, busy=0.
  - If start=1 at the edge: latch all eight operands, busy<=1, arr_rst_n<=0, go to CLEAR.
- CLEAR: arr_rst_n=0 for exactly one cycle; feeds=0. Next state GAP, with arr_rst_n<=1.
- GAP: arr_rst_n=1, feeds=0. This is the array reset-recovery cycle. Next state FEED0.
- Feed registers (each state holds exactly these values for one cycle; the array samples them at that cycle's closing edge):
  - FEED0: arr_a1=A11, arr_b1=B11, arr_a2=0, arr_b2=0.
  - FEED1: arr_a1=A12, arr_b1=B21, arr_a2=A21, arr_b2=B12.
  - FEED2: arr_a1=0, arr_b1=0, arr_a2=A22, arr_b2=B22.
- DRAIN: all feeds=0. PE(1,1) takes its final term at this cycle's closing edge.
- CAPTURE:
  - pc* are final. At the closing edge: res_c11<=pc11, res_c12<=pc12, res_c21<=pc21, res_c22<=pc22.
  - Same edge: done<=1, busy<=0, state<=IDLE.
- done is high for exactly one cycle; it clears at the next edge unless a new CAPTURE completes.
- Latency: start sampled at edge E0 gives done=1 and valid res_* in the cycle after edge E7. The next job can be accepted at E7+1.
- Throughput: one job per 8 cycles with start held high.
- Operand latching: operands latch only at job acceptance. Operand input changes while busy=1 have no effect on the current job.
- start while busy=1 is ignored; it is not queued.
- res_* hold their last captured values until the next CAPTURE or rst.
- Arithmetic: unsigned DWxDW products accumulate in the array at CW bits. Results wrap modulo 2^CW; there is no overflow flag.
- rst mid-job (any state): next cycle IDLE, busy=0, done=0, res_*=0, arr_rst_n=0 (array cleared). No done is issued for the aborted job.
- rst and start in the same cycle: rst wins; the job is not accepted.

Test Plan:
1. Reset → arr_rst_n=0, busy=0, done=0, res_*=0. Release rst, start=0 → arr_rst_n=1 next cycle, feeds stay 0.
2. A=[[1,2],[3,4]], B=[[5,6],[7,8]], one start pulse → busy for cycles 1-7, done exactly in cycle 8 after the sampling edge, res=[[19,22],[43,50]]. Check feed values per state against the schedule above.
3. A=[[255,255],[255,255]], B same → each true value is 130050, so res_*=31746 (mod 2^15).
4. Start held high for three jobs (identity x B, then A x identity, then zero matrices) → done every 8 cycles with correct res each time. Accumulators are cleared between jobs, so no carry-over from previous jobs.
5. Change a*/b* and pulse start while busy in FEED1 → current result unchanged, no extra job, done pulses once.
6. Assert rst during FEED1, release, then run the scenario-2 job → no done for the aborted job; second job returns [[19,22],[43,50]].
